// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Wishbone classic single-transfer initiator. Turns one command beat on the
//   valid/ready command port into exactly one bus cycle on the wbm_* port set
//   and one beat on the response port.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i      command payload (write flag, byte address, data, lanes)
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o      read data (0 for writes), watchdog abort flag
//   wbm_cyc_o ... wbm_sel_o   Wishbone master outputs
//   wbm_dat_i, wbm_ack_i      Wishbone slave return path
//
// Build option
//   WB_CMD_MASTER_TIMEOUT_EN  adds a 16-bit wait-state watchdog; a cycle not
//                             acknowledged within TIMEOUT BUS cycles is
//                             aborted and answered with rsp_err_o = 1.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a command, bus idle
// ST_BUS  | cyc/stb asserted, waiting for ack (or watchdog expiry)
// ST_RESP | response presented, waiting for rsp_ready_i
module wb_cmd_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [15:0] wdog_q, wdog_d;

  // wdog_q counts completed un-acked BUS cycles, so the current cycle is
  // number wdog_q + 1; an ack on that same cycle takes priority.
  assign timeout_hit = (state_q == ST_BUS) && !wbm_ack_i &&
                       ((wdog_q + 16'd1) == TIMEOUT_W);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_IDLE && cmd_valid_i) begin
      wdog_d = '0;
    end else if (state_q == ST_BUS && !wbm_ack_i) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d     = ST_BUS;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : ERR_DATA;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        cyc_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  // Classic single transfers: stb is never deasserted inside a cycle.
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
`timescale 1ns/1ps
module tb_wb_cmd_master;

  localparam int TMO   = 4;
  localparam int NOACK = 1000;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;

  wb_cmd_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
    .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    time         t_acc;
  } cmd_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    time         t_acc;
    int          lat;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          outstanding = 0;
  int          force_w = -1;
  logic [31:0] force_dat = '0;
  bit          rdy_rand = 1'b0;
  bit          abort = 1'b0;
  time         last_acc_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_cmd(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    bit ok = 1'b0;
    logic r;
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); r = cmd_ready_o;
      @(posedge clk);
      if (r === 1'b1) begin
        ok = 1'b1;
        last_acc_t = $time;
        cmd_q.push_back('{we, adr, dat, sel, $time});
        outstanding++;
      end
    end
    #1;
    cmd_valid_i = 1'b0;
    cmd_we_i = $urandom_range(1); cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);
    if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (outstanding == 0 && rsp_valid_o === 1'b0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(outstanding), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_cmd();
    send_cmd(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
  endtask

  // response ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) rsp_ready_i = 1'($urandom_range(1));
    end
  end

  // slave model: decides wait states and data, checks bus fields and cycle length
  initial begin
    bit          active = 1'b0;
    bit          hold = 1'b0;
    int          n = 0;
    int          w = 0;
    logic [31:0] d;
    cmd_t        cur;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0, 0};
    forever begin
      @(posedge clk); #1;
      if (wbm_cyc_o === 1'b1) begin
        if (!active) begin
          active = 1'b1; n = 0;
          if (cmd_q.size() == 0) chk("bus_unexpected_cycle", 32'd1, 32'd0);
          else cur = cmd_q.pop_front();
          if (force_w >= 0) w = force_w;
          else begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            w = ($urandom_range(3) == 0) ? NOACK : $urandom_range(TMO - 1);
`else
            w = $urandom_range(5);
`endif
          end
        end
        chk("bus_stb", 32'(wbm_stb_o), 32'd1);
        chk("bus_we", 32'(wbm_we_o), 32'(cur.we));
        chk("bus_adr", wbm_adr_o, cur.adr);
        chk("bus_dat", wbm_dat_o, cur.dat);
        chk("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
        if (n == w) begin
          d = (force_w >= 0) ? force_dat : $urandom;
          wbm_ack_i = 1'b1;
          wbm_dat_i = d;
          rsp_q.push_back('{cur.we ? 32'h0 : d, 1'b0, cur.t_acc, w + 2});
          hold = ($urandom_range(2) == 0);
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = $urandom;
        end
        n++;
      end else begin
        if (active) begin
          active = 1'b0;
          if (abort) abort = 1'b0;
          else if (w == NOACK) begin
            chk("bus_len_timeout", 32'(n), 32'(TMO));
            rsp_q.push_back('{cur.we ? 32'h0 : 32'hDEAD_BEEF, 1'b1, cur.t_acc, TMO + 1});
          end else chk("bus_len", 32'(n), 32'(w + 1));
        end
        // held-over and spurious acks outside a bus cycle
        wbm_ack_i = hold || ($urandom_range(4) == 0);
        hold = 1'b0;
        wbm_dat_i = $urandom;
      end
    end
  end

  // response monitor / scoreboard and invariants
  initial begin
    bit          prev_stall = 1'b0;
    bit          prev_valid = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_err = 1'b0;
    rsp_t        e;
    forever begin
      @(negedge clk);
      if (wb_rst_i === 1'b0) begin
        chk("cmd_ready", 32'(cmd_ready_o), 32'(outstanding == 0));
        chk("stb_eq_cyc", 32'(wbm_stb_o), 32'(wbm_cyc_o));
        if (outstanding == 0) begin
          chk("idle_cyc", 32'(wbm_cyc_o), 32'd0);
          chk("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
        end
        if (prev_stall) begin
          chk("rsp_hold_valid", 32'(rsp_valid_o), 32'd1);
          chk("rsp_hold_dat", rsp_dat_o, prev_dat);
          chk("rsp_hold_err", 32'(rsp_err_o), 32'(prev_err));
        end
        if (rsp_valid_o === 1'b1 && !prev_valid) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
          else chk("rsp_latency", 32'(($time + 5 - rsp_q[0].t_acc) / 10), 32'(rsp_q[0].lat));
        end
        if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected_beat", 32'd1, 32'd0);
          else begin
            e = rsp_q.pop_front();
            chk("rsp_dat", rsp_dat_o, e.dat);
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          end
          outstanding--;
        end
      end
      prev_valid = (rsp_valid_o === 1'b1);
      prev_stall = (rsp_valid_o === 1'b1) && (rsp_ready_i !== 1'b1);
      prev_dat   = rsp_dat_o;
      prev_err   = rsp_err_o;
    end
  end

  initial begin
    time t_h;
    repeat (2) @(posedge clk);
    #1 wb_rst_i = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_rsp_dat", rsp_dat_o, 32'd0);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    @(posedge clk); #1;

    rsp_ready_i = 1'b1;
    force_w = 0;
    send_cmd(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
    wait_idle();
    force_w = 3; force_dat = 32'hCAFE_F00D;
    send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    wait_idle();

    // response back-pressure with the next command already waiting
    force_w = 0; force_dat = 32'h0BAD_CAFE;
    rsp_ready_i = 1'b0;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'h3);
    fork
      send_cmd(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'hC);
      begin
        repeat (6) @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        @(posedge clk);
        t_h = $time;
      end
    join
    chk("accept_after_ready", 32'((last_acc_t - t_h) / 10), 32'd1);
    wait_idle();

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    force_w = NOACK;
    send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    wait_idle();
    force_w = TMO - 1; force_dat = 32'h1357_9BDF;
    send_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    wait_idle();
`endif

    force_w = -1;
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      rand_cmd();
    end
    wait_idle();
    rdy_rand = 1'b0;
    rsp_ready_i = 1'b1;

    // reset in the middle of a bus cycle
    force_w = 50;
    send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    @(posedge clk); #1;
    abort = 1'b1;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    outstanding = 0;
    @(negedge clk);
    chk("midrst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("midrst_stb", 32'(wbm_stb_o), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    force_w = -1;
    rand_cmd();
    wait_idle();
    chk("scoreboard_empty", 32'(rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
